// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC and drives the instruction memory.
// It registers each fetched word into a valid/ready slot toward decode.
module fetch_ctrl #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned RESET_PC = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0] imem_instr,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             if_valid,
  input  logic             if_ready,
  output logic [WIDTH-1:0] if_instr,
  output logic [WIDTH-1:0] if_pc,
  output logic             fault,
  output logic [WIDTH-1:0] fault_pc,
  input  logic             fault_clear
);

  localparam logic [WIDTH-1:0] LAST_PC  = WIDTH'(4 * DEPTH - 4);
  localparam logic [WIDTH-1:0] BOOT_PC  = WIDTH'(RESET_PC);
  localparam logic [WIDTH-1:0] PC_STEP  = WIDTH'(4);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FAULT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] ipc_q, ipc_d;
  logic             fault_q, fault_d;
  logic [WIDTH-1:0] fpc_q, fpc_d;

  logic [WIDTH-1:0] pc_inc;
  logic             pc_carry;
  logic             inc_bad;
  logic             redir_bad;
  logic             slot_free;

  // Carry out of pc+4 counts as out of range rather than wrapping.
  assign {pc_carry, pc_inc} = {1'b0, pc_q} + {1'b0, PC_STEP};
  assign inc_bad   = pc_carry || (pc_inc > LAST_PC);
  assign redir_bad = (redirect_pc[1:0] != 2'b00) || (redirect_pc > LAST_PC);
  assign slot_free = !valid_q || if_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    fault_d = fault_q;
    fpc_d   = fpc_q;
    unique case (state_q)
      BOOT: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (redirect_valid) begin
          valid_d = 1'b0;
          if (redir_bad) begin
            state_d = FAULT;
            fault_d = 1'b1;
            fpc_d   = redirect_pc;
          end else begin
            pc_d = redirect_pc;
          end
        end else if (stall) begin
          valid_d = valid_q && !if_ready;
        end else if (slot_free) begin
          instr_d = imem_instr;
          ipc_d   = pc_q;
          valid_d = 1'b1;
          if (inc_bad) begin
            state_d = FAULT;
            fault_d = 1'b1;
            fpc_d   = pc_inc;
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      FAULT: begin
        if (fault_clear) begin
          state_d = BOOT;
          pc_d    = BOOT_PC;
          fault_d = 1'b0;
          fpc_d   = '0;
          valid_d = 1'b0;
        end else if (if_ready) begin
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= BOOT_PC;
      valid_q <= 1'b0;
      instr_q <= '0;
      ipc_q   <= '0;
      fault_q <= 1'b0;
      fpc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      fault_q <= fault_d;
      fpc_q   <= fpc_d;
    end
  end

  assign imem_addr = pc_q;
  assign if_valid  = valid_q;
  assign if_instr  = instr_q;
  assign if_pc     = ipc_q;
  assign fault     = fault_q;
  assign fault_pc  = fpc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a combinational memory model.
// Expected values are hand-computed from the fetch behaviour.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        fault;
  logic [31:0] fault_pc;
  logic        fault_clear;

  logic [31:0] mem [0:31];
  int checks;
  int errors;

  fetch_ctrl #(.WIDTH(32), .DEPTH(32), .RESET_PC(0)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_addr(imem_addr),
    .imem_instr(imem_instr),
    .stall(stall),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .if_valid(if_valid),
    .if_ready(if_ready),
    .if_instr(if_instr),
    .if_pc(if_pc),
    .fault(fault),
    .fault_pc(fault_pc),
    .fault_clear(fault_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_instr = mem[imem_addr[6:2]];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h1000 + i;
    mem[0] = 32'h11;
    mem[1] = 32'h22;
    mem[2] = 32'h33;
    rst_n = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    if_ready = 1'b1;
    fault_clear = 1'b0;

    // reset state
    step();
    step();
    chk("rst_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_fpc", fault_pc, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    rst_n = 1'b1;

    // boot bubble then streaming
    step();
    chk("boot_valid", {31'b0, if_valid}, 32'd0);
    step();
    chk("e2_valid", {31'b0, if_valid}, 32'd1);
    chk("e2_pc", if_pc, 32'h0);
    chk("e2_instr", if_instr, 32'h11);
    chk("e2_addr", imem_addr, 32'h4);
    step();
    chk("e3_pc", if_pc, 32'h4);
    chk("e3_instr", if_instr, 32'h22);
    step();
    chk("e4_pc", if_pc, 32'h8);
    chk("e4_instr", if_instr, 32'h33);
    chk("e4_addr", imem_addr, 32'hC);

    // backpressure
    if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_valid", {31'b0, if_valid}, 32'd1);
      chk("bp_pc", if_pc, 32'h8);
      chk("bp_instr", if_instr, 32'h33);
      chk("bp_addr", imem_addr, 32'hC);
    end
    if_ready = 1'b1;
    step();
    chk("bp_rel_pc", if_pc, 32'hC);
    chk("bp_rel_instr", if_instr, 32'h1003);

    // good redirect
    redirect_valid = 1'b1;
    redirect_pc = 32'h10;
    step();
    redirect_valid = 1'b0;
    chk("rd_flush", {31'b0, if_valid}, 32'd0);
    chk("rd_addr", imem_addr, 32'h10);
    step();
    chk("rd_valid", {31'b0, if_valid}, 32'd1);
    chk("rd_pc", if_pc, 32'h10);
    chk("rd_instr", if_instr, 32'h1004);

    // stall with ready: slot drains, pc holds
    stall = 1'b1;
    step();
    chk("st_valid", {31'b0, if_valid}, 32'd0);
    chk("st_addr", imem_addr, 32'h14);
    stall = 1'b0;
    step();
    chk("st_rel_pc", if_pc, 32'h14);

    // misaligned redirect
    redirect_valid = 1'b1;
    redirect_pc = 32'h06;
    step();
    chk("mis_fault", {31'b0, fault}, 32'd1);
    chk("mis_fpc", fault_pc, 32'h06);
    chk("mis_valid", {31'b0, if_valid}, 32'd0);
    redirect_pc = 32'h20;
    step();
    redirect_valid = 1'b0;
    chk("flt_ign_addr", imem_addr, 32'h18);
    chk("flt_ign_fpc", fault_pc, 32'h06);
    fault_clear = 1'b1;
    step();
    fault_clear = 1'b0;
    chk("clr_fault", {31'b0, fault}, 32'd0);
    chk("clr_fpc", fault_pc, 32'd0);
    chk("clr_addr", imem_addr, 32'd0);
    step();
    chk("clr_boot", {31'b0, if_valid}, 32'd0);
    step();
    chk("clr_valid", {31'b0, if_valid}, 32'd1);
    chk("clr_pc", if_pc, 32'h0);

    // sequential run to the last word
    redirect_valid = 1'b1;
    redirect_pc = 32'h70;
    step();
    redirect_valid = 1'b0;
    for (int a = 32'h70; a <= 32'h78; a += 4) begin
      step();
      chk("end_pc", if_pc, 32'(a));
      chk("end_nofault", {31'b0, fault}, 32'd0);
    end
    step();
    chk("last_pc", if_pc, 32'h7C);
    chk("last_instr", if_instr, 32'h101F);
    chk("last_valid", {31'b0, if_valid}, 32'd1);
    chk("last_fault", {31'b0, fault}, 32'd1);
    chk("last_fpc", fault_pc, 32'h80);
    chk("last_addr", imem_addr, 32'h7C);
    step();
    chk("last_drain", {31'b0, if_valid}, 32'd0);
    chk("last_hold", imem_addr, 32'h7C);

    fault_clear = 1'b1;
    step();
    fault_clear = 1'b0;
    step();
    step();
    chk("re_pc", if_pc, 32'h0);

    // async reset mid-stream
    if_ready = 1'b0;
    stall = 1'b1;
    step();
    chk("mid_valid", {31'b0, if_valid}, 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'b0, if_valid}, 32'd0);
    chk("ar_addr", imem_addr, 32'd0);
    chk("ar_pc", if_pc, 32'd0);
    chk("ar_instr", if_instr, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    stall = 1'b0;
    if_ready = 1'b1;
    step();
    chk("ar_boot", {31'b0, if_valid}, 32'd0);
    step();
    chk("ar_valid2", {31'b0, if_valid}, 32'd1);
    chk("ar_instr2", if_instr, 32'h11);
    fault_clear = 1'b1;
    step();
    fault_clear = 1'b0;
    chk("fc_noeff_pc", if_pc, 32'h4);
    chk("fc_noeff_fault", {31'b0, fault}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
